// File: rtl/sad_search_engine.sv
// sad_search_engine
// Streaming sum-of-absolute-differences engine for block-matching motion
// estimation. Each beat carries LANES pixel pairs and BEATS beats make one
// candidate block. A three-stage pipeline produces one SAD per candidate,
// and the engine tracks the minimum SAD and its candidate index over a
// search of NUM_CAND candidates.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no search active, in_valid ignored, waiting for search_start
// ST_RUN   | accepting beats on in_valid until the last beat of the last
//          | candidate is taken
// ST_DRAIN | input ignored, pipeline emptying; third cycle carries the
//          | final sad_valid together with done
//
// Pipeline (no stall, no backpressure):
//   S1  per-lane |a-b|
//   S2  adder-tree sum of the lanes
//   S3  per-candidate accumulator, SAD output register, running minimum
// A beat presented in cycle t leaves S3 in cycle t+3.

module sad_search_engine #(
    parameter  int PIX_W    = 8,
    parameter  int LANES    = 4,
    parameter  int BEATS    = 4,
    parameter  int NUM_CAND = 16,
    localparam int SAD_W    = PIX_W + $clog2(LANES * BEATS),
    localparam int IDX_W    = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_search_start,
    input  logic                     i_in_valid,
    input  logic [LANES*PIX_W-1:0]   i_a_pix,
    input  logic [LANES*PIX_W-1:0]   i_b_pix,
    output logic                     o_sad_valid,
    output logic [SAD_W-1:0]         o_sad,
    output logic [IDX_W-1:0]         o_sad_idx,
    output logic [SAD_W-1:0]         o_best_sad,
    output logic [IDX_W-1:0]         o_best_idx,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int SUM_W  = PIX_W + $clog2(LANES);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [IDX_W-1:0]  LAST_CAND = IDX_W'(NUM_CAND - 1);
    localparam logic [1:0]        DRAIN_END = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_drain_cnt;

    logic [BEAT_W-1:0]   r_beat_cnt;
    logic [IDX_W-1:0]    r_cand_cnt;

    logic                w_accept;
    logic [BEAT_W-1:0]   w_beat_cur;
    logic [IDX_W-1:0]    w_cand_cur;
    logic                w_first_beat;
    logic                w_last_beat;
    logic                w_last_cand;

    logic [PIX_W-1:0]    w_abs [LANES];

    logic                r_s1_valid;
    logic                r_s1_first;
    logic                r_s1_last;
    logic [IDX_W-1:0]    r_s1_idx;
    logic [PIX_W-1:0]    r_s1_abs [LANES];

    logic [SUM_W-1:0]    w_s1_sum;

    logic                r_s2_valid;
    logic                r_s2_first;
    logic                r_s2_last;
    logic [IDX_W-1:0]    r_s2_idx;
    logic [SUM_W-1:0]    r_s2_sum;

    logic                w_s3_fire;
    logic                w_s3_emit;
    logic [SAD_W-1:0]    w_acc_next;

    logic [SAD_W-1:0]    r_acc;
    logic                r_sad_valid;
    logic [SAD_W-1:0]    r_sad;
    logic [IDX_W-1:0]    r_sad_idx;
    logic [SAD_W-1:0]    r_best_sad;
    logic [IDX_W-1:0]    r_best_idx;

    // A start pulse restarts the counters in the same cycle, so a beat
    // presented alongside it is already seen as beat 0 of candidate 0.
    assign w_accept     = i_in_valid && (i_search_start || (r_state == ST_RUN));
    assign w_beat_cur   = i_search_start ? '0 : r_beat_cnt;
    assign w_cand_cur   = i_search_start ? '0 : r_cand_cnt;
    assign w_first_beat = (w_beat_cur == '0);
    assign w_last_beat  = (w_beat_cur == LAST_BEAT);
    assign w_last_cand  = (w_cand_cur == LAST_CAND);

    // Beat and candidate position of the next accepted beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_beat_cnt <= '0;
            r_cand_cnt <= '0;
        end else if (w_accept) begin
            if (w_last_beat) begin
                r_beat_cnt <= '0;
                r_cand_cnt <= w_cand_cur + IDX_W'(1);
            end else begin
                r_beat_cnt <= w_beat_cur + BEAT_W'(1);
                r_cand_cnt <= w_cand_cur;
            end
        end else if (i_search_start) begin
            r_beat_cnt <= '0;
            r_cand_cnt <= '0;
        end
    end

    // Per-lane absolute difference, formed as a signed PIX_W+1 subtraction.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [PIX_W:0] w_diff;
        assign w_diff   = $signed({1'b0, i_a_pix[g*PIX_W +: PIX_W]})
                        - $signed({1'b0, i_b_pix[g*PIX_W +: PIX_W]});
        assign w_abs[g] = w_diff[PIX_W] ? PIX_W'(-w_diff) : PIX_W'(w_diff);
    end

    // S1: register lane differences with the beat's position tags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_idx   <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_s1_abs[i] <= '0;
            end
        end else begin
            r_s1_valid <= w_accept;
            r_s1_first <= w_first_beat;
            r_s1_last  <= w_last_beat;
            r_s1_idx   <= w_cand_cur;
            for (int i = 0; i < LANES; i++) begin
                r_s1_abs[i] <= w_abs[i];
            end
        end
    end

    // Lane sum feeding S2; synthesis is free to balance it into a tree.
    always_comb begin
        w_s1_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_s1_sum = w_s1_sum + SUM_W'(r_s1_abs[i]);
        end
    end

    // S2: register the beat sum; a start pulse drops whatever S1 held.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s2_valid <= 1'b0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_idx   <= '0;
            r_s2_sum   <= '0;
        end else begin
            r_s2_valid <= r_s1_valid && !i_search_start;
            r_s2_first <= r_s1_first;
            r_s2_last  <= r_s1_last;
            r_s2_idx   <= r_s1_idx;
            r_s2_sum   <= w_s1_sum;
        end
    end

    // The first beat of a candidate loads the accumulator, later beats add.
    assign w_s3_fire  = r_s2_valid && !i_search_start;
    assign w_s3_emit  = w_s3_fire && r_s2_last;
    assign w_acc_next = r_s2_first ? SAD_W'(r_s2_sum)
                                   : r_acc + SAD_W'(r_s2_sum);

    // S3: accumulate, publish the finished SAD and keep the strict minimum
    // so that ties stay with the earlier candidate.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc       <= '0;
            r_sad_valid <= 1'b0;
            r_sad       <= '0;
            r_sad_idx   <= '0;
            r_best_sad  <= '1;
            r_best_idx  <= '0;
        end else begin
            r_sad_valid <= w_s3_emit;
            if (w_s3_fire) begin
                r_acc <= w_acc_next;
            end
            if (w_s3_emit) begin
                r_sad     <= w_acc_next;
                r_sad_idx <= r_s2_idx;
            end
            if (i_search_start) begin
                r_best_sad <= '1;
                r_best_idx <= '0;
            end else if (w_s3_emit && (w_acc_next < r_best_sad)) begin
                r_best_sad <= w_acc_next;
                r_best_idx <= r_s2_idx;
            end
        end
    end

    // FSM state register; the drain counter times the three DRAIN cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == ST_DRAIN) && (w_state_next == ST_DRAIN)) begin
                r_drain_cnt <= r_drain_cnt + 2'd1;
            end else begin
                r_drain_cnt <= '0;
            end
        end
    end

    // FSM next-state logic; search_start overrides every state.
    always_comb begin
        w_state_next = r_state;
        if (i_search_start) begin
            if (w_accept && w_last_beat && w_last_cand) begin
                w_state_next = ST_DRAIN;
            end else begin
                w_state_next = ST_RUN;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next = ST_IDLE;
                end
                ST_RUN: begin
                    if (w_accept && w_last_beat && w_last_cand) begin
                        w_state_next = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == DRAIN_END) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // FSM outputs; the last DRAIN cycle is the one carrying the final SAD.
    always_comb begin
        o_busy = (r_state != ST_IDLE);
        o_done = (r_state == ST_DRAIN) && (r_drain_cnt == DRAIN_END);
    end

    assign o_sad_valid = r_sad_valid;
    assign o_sad       = r_sad;
    assign o_sad_idx   = r_sad_idx;
    assign o_best_sad  = r_best_sad;
    assign o_best_idx  = r_best_idx;

endmodule

// File: tb/tb_sad_search_engine.sv
// tb_sad_search_engine
// Drives whole searches into sad_search_engine and compares every reported
// SAD, index, running best and timing against a reference computed directly
// from the pixel arrays with integer arithmetic.

module tb_sad_search_engine;

    localparam int PIX_W    = 8;
    localparam int LANES    = 4;
    localparam int BEATS    = 4;
    localparam int NUM_CAND = 16;
    localparam int SAD_W    = PIX_W + $clog2(LANES * BEATS);
    localparam int IDX_W    = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
    localparam int SAD_ONES = (1 << SAD_W) - 1;
    localparam int PIX_MAX  = (1 << PIX_W) - 1;

    logic                   clk;
    logic                   rst;
    logic                   search_start;
    logic                   in_valid;
    logic [LANES*PIX_W-1:0] a_pix;
    logic [LANES*PIX_W-1:0] b_pix;
    logic                   sad_valid;
    logic [SAD_W-1:0]       sad;
    logic [IDX_W-1:0]       sad_idx;
    logic [SAD_W-1:0]       best_sad;
    logic [IDX_W-1:0]       best_idx;
    logic                   busy;
    logic                   done;

    sad_search_engine #(
        .PIX_W    (PIX_W),
        .LANES    (LANES),
        .BEATS    (BEATS),
        .NUM_CAND (NUM_CAND)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_search_start (search_start),
        .i_in_valid     (in_valid),
        .i_a_pix        (a_pix),
        .i_b_pix        (b_pix),
        .o_sad_valid    (sad_valid),
        .o_sad          (sad),
        .o_sad_idx      (sad_idx),
        .o_best_sad     (best_sad),
        .o_best_idx     (best_idx),
        .o_busy         (busy),
        .o_done         (done)
    );

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;
    int          cyc        = 0;

    int a_mem [NUM_CAND][BEATS][LANES];
    int b_mem [NUM_CAND][BEATS][LANES];
    int exp_sad  [NUM_CAND];
    int exp_best [NUM_CAND];
    int exp_bidx [NUM_CAND];
    int exp_cyc [$];

    logic [31:0] obs_sad  [$];
    logic [31:0] obs_idx  [$];
    logic [31:0] obs_best [$];
    logic [31:0] obs_bidx [$];
    int          obs_cyc  [$];
    int          done_cyc [$];
    logic        busy_after_done [$];
    logic        prev_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record everything the DUT reports, sampled mid-cycle.
    always @(negedge clk) begin
        if (prev_done) busy_after_done.push_back(busy);
        prev_done = done;
        if (sad_valid === 1'b1) begin
            obs_sad.push_back(32'(sad));
            obs_idx.push_back(32'(sad_idx));
            obs_best.push_back(32'(best_sad));
            obs_bidx.push_back(32'(best_idx));
            obs_cyc.push_back(cyc);
        end
        if (done === 1'b1) done_cyc.push_back(cyc);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, want $finish before time limit");
        $fatal(1, "time limit");
    end

    function automatic logic [LANES*PIX_W-1:0] rand_vec();
        logic [LANES*PIX_W-1:0] v;
        for (int ln = 0; ln < LANES; ln++) v[ln*PIX_W +: PIX_W] = PIX_W'($urandom_range(PIX_MAX));
        return v;
    endfunction

    function automatic logic [LANES*PIX_W-1:0] pack_a(int c, int bt);
        logic [LANES*PIX_W-1:0] v;
        for (int ln = 0; ln < LANES; ln++) v[ln*PIX_W +: PIX_W] = PIX_W'(a_mem[c][bt][ln]);
        return v;
    endfunction

    function automatic logic [LANES*PIX_W-1:0] pack_b(int c, int bt);
        logic [LANES*PIX_W-1:0] v;
        for (int ln = 0; ln < LANES; ln++) v[ln*PIX_W +: PIX_W] = PIX_W'(b_mem[c][bt][ln]);
        return v;
    endfunction

    // Reference: SAD is the plain sum of |a-b| over the block; best is the
    // first candidate reaching the strict minimum so far.
    task automatic compute_model();
        int best;
        int bidx;
        best = SAD_ONES;
        bidx = 0;
        for (int c = 0; c < NUM_CAND; c++) begin
            int s;
            s = 0;
            for (int bt = 0; bt < BEATS; bt++)
                for (int ln = 0; ln < LANES; ln++) begin
                    int d;
                    d = a_mem[c][bt][ln] - b_mem[c][bt][ln];
                    s += (d < 0) ? -d : d;
                end
            if (s < best) begin
                best = s;
                bidx = c;
            end
            exp_sad[c]  = s;
            exp_best[c] = best;
            exp_bidx[c] = bidx;
        end
    endtask

    task automatic fill_random();
        for (int c = 0; c < NUM_CAND; c++)
            for (int bt = 0; bt < BEATS; bt++)
                for (int ln = 0; ln < LANES; ln++) begin
                    a_mem[c][bt][ln] = $urandom_range(PIX_MAX);
                    b_mem[c][bt][ln] = $urandom_range(PIX_MAX);
                end
    endtask

    task automatic fill_cand(int c, int a, int b);
        for (int bt = 0; bt < BEATS; bt++)
            for (int ln = 0; ln < LANES; ln++) begin
                a_mem[c][bt][ln] = a;
                b_mem[c][bt][ln] = b;
            end
    endtask

    task automatic clear_obs();
        obs_sad.delete();
        obs_idx.delete();
        obs_best.delete();
        obs_bidx.delete();
        obs_cyc.delete();
        done_cyc.delete();
        busy_after_done.delete();
    endtask

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic cycle_in(input logic v, input logic s,
                            input logic [LANES*PIX_W-1:0] a,
                            input logic [LANES*PIX_W-1:0] b);
        in_valid     = v;
        search_start = s;
        a_pix        = a;
        b_pix        = b;
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        search_start = 1'b0;
    endtask

    // mode 0: lone start pulse first; 1: start together with beat 0;
    // 2: start and beat 0 already sent by the caller.
    task automatic send_search_beats(input int pct, input int mode);
        exp_cyc.delete();
        if (mode == 0) cycle_in(1'b0, 1'b1, rand_vec(), rand_vec());
        for (int c = 0; c < NUM_CAND; c++)
            for (int bt = 0; bt < BEATS; bt++) begin
                int n;
                if (mode == 2 && c == 0 && bt == 0) continue;
                n = 0;
                while (n < 8 && $urandom_range(99) < pct) begin
                    cycle_in(1'b0, 1'b0, rand_vec(), rand_vec());
                    n++;
                end
                if (bt == BEATS - 1) exp_cyc.push_back(cyc);
                cycle_in(1'b1, (mode == 1 && c == 0 && bt == 0), pack_a(c, bt), pack_b(c, bt));
            end
    endtask

    task automatic test_search_vs_model(input string tag, input int pct, input int mode);
        int n;
        if (mode != 2) clear_obs();
        compute_model();
        send_search_beats(pct, mode);
        repeat (6) cycle_in(1'b0, 1'b0, rand_vec(), rand_vec());

        vectors++;
        if (obs_sad.size() !== NUM_CAND) begin
            miscompares++;
            $display("FAIL %s sad_valid_count: got %0d want %0d", tag, obs_sad.size(), NUM_CAND);
        end
        n = (obs_sad.size() < NUM_CAND) ? obs_sad.size() : NUM_CAND;
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (obs_sad[i] !== 32'(exp_sad[i])) begin
                miscompares++;
                $display("FAIL %s sad[%0d]: got %0d want %0d", tag, i, obs_sad[i], exp_sad[i]);
            end
            vectors++;
            if (obs_idx[i] !== 32'(i)) begin
                miscompares++;
                $display("FAIL %s sad_idx[%0d]: got %0d want %0d", tag, i, obs_idx[i], i);
            end
            vectors++;
            if (obs_best[i] !== 32'(exp_best[i]) || obs_bidx[i] !== 32'(exp_bidx[i])) begin
                miscompares++;
                $display("FAIL %s best[%0d]: got %0d@%0d want %0d@%0d", tag, i,
                         obs_best[i], obs_bidx[i], exp_best[i], exp_bidx[i]);
            end
            vectors++;
            if (obs_cyc[i] !== exp_cyc[i] + 3) begin
                miscompares++;
                $display("FAIL %s latency[%0d]: got cycle %0d want %0d", tag, i, obs_cyc[i], exp_cyc[i] + 3);
            end
        end
        vectors++;
        if (done_cyc.size() !== 1 || done_cyc[0] !== exp_cyc[NUM_CAND-1] + 3) begin
            miscompares++;
            $display("FAIL %s done: got %0d pulses first at %0d want 1 at %0d", tag,
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, exp_cyc[NUM_CAND-1] + 3);
        end
        vectors++;
        if (busy_after_done.size() !== 1 || busy_after_done[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_after_done: got %0d samples first %b want 1 sample 0", tag,
                     busy_after_done.size(), (busy_after_done.size() > 0) ? busy_after_done[0] : 1'bx);
        end
        vectors++;
        if (best_sad !== SAD_W'(exp_best[NUM_CAND-1]) || best_idx !== IDX_W'(exp_bidx[NUM_CAND-1]) || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s final: got best %0d@%0d busy %b want %0d@%0d busy 0", tag,
                     best_sad, best_idx, busy, exp_best[NUM_CAND-1], exp_bidx[NUM_CAND-1]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle_in(1'b1, 1'b1, rand_vec(), rand_vec());
        cycle_in(1'b0, 1'b0, rand_vec(), rand_vec());
        vectors++;
        if (sad_valid !== 1'b0 || sad !== '0 || sad_idx !== '0) begin
            miscompares++;
            $display("FAIL reset_sad: got v=%b sad=%0d idx=%0d want 0 0 0", sad_valid, sad, sad_idx);
        end
        vectors++;
        if (best_sad !== SAD_W'(SAD_ONES) || best_idx !== '0) begin
            miscompares++;
            $display("FAIL reset_best: got %0d@%0d want %0d@0", best_sad, best_idx, SAD_ONES);
        end
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got busy=%b done=%b want 0 0", busy, done);
        end
        rst = 1'b0;
        clear_obs();
        repeat (2 * BEATS * 3) cycle_in(1'b1, 1'b0, rand_vec(), rand_vec());
        repeat (5) cycle_in(1'b0, 1'b0, rand_vec(), rand_vec());
        vectors++;
        if (obs_sad.size() !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_ignores_input: got %0d sad_valid busy=%b want 0 0", obs_sad.size(), busy);
        end
    endtask

    task automatic test_uniform();
        for (int c = 0; c < NUM_CAND; c++) fill_cand(c, 10, 7);
        test_search_vs_model("uniform", 0, 0);
        vectors++;
        if (obs_sad.size() == 0 || obs_sad[0] !== 32'd48 || best_sad !== SAD_W'(48) || best_idx !== '0) begin
            miscompares++;
            $display("FAIL uniform_literal: got sad0=%0d best=%0d@%0d want 48 48@0",
                     (obs_sad.size() > 0) ? obs_sad[0] : 32'hx, best_sad, best_idx);
        end
    endtask

    task automatic test_extremes();
        int v;
        fill_random();
        fill_cand(0, PIX_MAX, 0);
        fill_cand(1, 0, PIX_MAX);
        for (int bt = 0; bt < BEATS; bt++)
            for (int ln = 0; ln < LANES; ln++) begin
                v = $urandom_range(PIX_MAX);
                a_mem[2][bt][ln] = v;
                b_mem[2][bt][ln] = v;
            end
        test_search_vs_model("extremes", 10, 1);
        vectors++;
        if (obs_sad.size() < 2 || obs_sad[0] !== 32'd4080 || obs_sad[1] !== 32'd4080
            || best_sad !== '0 || best_idx !== IDX_W'(2)) begin
            miscompares++;
            $display("FAIL extremes_literal: got sad0/1=%0d/%0d best=%0d@%0d want 4080/4080 0@2",
                     (obs_sad.size() > 0) ? obs_sad[0] : 32'hx, (obs_sad.size() > 1) ? obs_sad[1] : 32'hx,
                     best_sad, best_idx);
        end
    endtask

    task automatic test_min_ties();
        int tgt [4] = '{100, 40, 40, 60};
        int v;
        for (int c = 0; c < NUM_CAND; c++) begin
            for (int bt = 0; bt < BEATS; bt++)
                for (int ln = 0; ln < LANES; ln++) begin
                    v = $urandom_range(PIX_MAX);
                    a_mem[c][bt][ln] = v;
                    b_mem[c][bt][ln] = v;
                end
            a_mem[c][0][0] = 0;
            b_mem[c][0][0] = (c < 4) ? tgt[c] : 200;
        end
        test_search_vs_model("min_ties", 20, 1);
        vectors++;
        if (best_sad !== SAD_W'(40) || best_idx !== IDX_W'(1)) begin
            miscompares++;
            $display("FAIL ties_literal: got %0d@%0d want 40@1", best_sad, best_idx);
        end
    endtask

    task automatic test_random_bubbles();
        fill_random();
        test_search_vs_model("bubbles_a", 50, 0);
        fill_random();
        test_search_vs_model("bubbles_b", 50, 1);
    endtask

    task automatic test_restart();
        clear_obs();
        fill_random();
        compute_model();
        cycle_in(1'b0, 1'b1, rand_vec(), rand_vec());
        for (int c = 0; c < 5; c++)
            for (int bt = 0; bt < BEATS; bt++) cycle_in(1'b1, 1'b0, pack_a(c, bt), pack_b(c, bt));
        repeat (6) cycle_in(1'b0, 1'b0, rand_vec(), rand_vec());
        vectors++;
        if (obs_sad.size() !== 5) begin
            miscompares++;
            $display("FAIL restart_pre_count: got %0d want 5", obs_sad.size());
        end
        for (int i = 0; i < obs_sad.size() && i < 5; i++) begin
            vectors++;
            if (obs_sad[i] !== 32'(exp_sad[i])) begin
                miscompares++;
                $display("FAIL restart_pre_sad[%0d]: got %0d want %0d", i, obs_sad[i], exp_sad[i]);
            end
        end
        cycle_in(1'b1, 1'b0, pack_a(5, 0), pack_b(5, 0));
        cycle_in(1'b1, 1'b0, pack_a(5, 1), pack_b(5, 1));
        clear_obs();
        fill_random();
        cycle_in(1'b1, 1'b1, pack_a(0, 0), pack_b(0, 0));
        vectors++;
        if (best_sad !== SAD_W'(SAD_ONES) || best_idx !== '0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_best_clear: got %0d@%0d busy=%b want %0d@0 busy 1",
                     best_sad, best_idx, busy, SAD_ONES);
        end
        test_search_vs_model("restart", 0, 2);
    endtask

    task automatic test_reset_in_drain();
        clear_obs();
        fill_random();
        compute_model();
        send_search_beats(0, 1);
        rst = 1'b1;
        cycle_in(1'b0, 1'b0, rand_vec(), rand_vec());
        vectors++;
        if (sad_valid !== 1'b0 || sad !== '0 || sad_idx !== '0 || best_sad !== SAD_W'(SAD_ONES)
            || best_idx !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_reset_values: got v=%b sad=%0d idx=%0d best=%0d@%0d busy=%b done=%b",
                     sad_valid, sad, sad_idx, best_sad, best_idx, busy, done);
        end
        rst = 1'b0;
        repeat (3 * BEATS) cycle_in(1'b1, 1'b0, rand_vec(), rand_vec());
        repeat (5) cycle_in(1'b0, 1'b0, rand_vec(), rand_vec());
        vectors++;
        if (obs_sad.size() !== NUM_CAND - 1 || done_cyc.size() !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_reset_quiet: got %0d sad_valid %0d done busy=%b want %0d 0 0",
                     obs_sad.size(), done_cyc.size(), busy, NUM_CAND - 1);
        end
    endtask

    initial begin
        rst          = 1'b1;
        search_start = 1'b0;
        in_valid     = 1'b0;
        a_pix        = '0;
        b_pix        = '0;
        #1;
        test_reset();
        test_uniform();
        test_extremes();
        test_min_ties();
        test_random_bubbles();
        test_restart();
        test_reset_in_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
